// File: rtl/stream_mux_rr_if.sv
// ---------------------------------------------------------------------------
// stream_mux_rr_if
// Bundle of the handshake and data signals around stream_mux_rr.
//   in_data   N*W  channel i occupies bits [i*W +: W]
//   in_valid  N    channel i offers a word
//   in_ready  N    channel i word consumed this cycle (one-hot or zero)
//   mode      1    0 = round-robin, 1 = fixed select
//   sel       SEL_W channel used when mode=1
//   out_data  W    registered output word
//   out_valid 1    out_data holds a word
//   out_ready 1    consumer accepts out_data this cycle
//   out_sel   SEL_W channel index out_data came from
// master: producers/consumer side (drives inputs of the mux)
// slave : the multiplexer itself
// ---------------------------------------------------------------------------
interface stream_mux_rr_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SEL_W = $clog2(N);

  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_sel;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
endinterface

// File: rtl/stream_mux_rr.sv
// ---------------------------------------------------------------------------
// stream_mux_rr
// N-input, W-bit registered stream multiplexer with round-robin or
// fixed-select arbitration. One output register stage: a word accepted on
// an edge is visible on out_data/out_valid right after that edge, and a
// drained slot can be refilled on the same edge (one word per cycle).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset (clears the output slot and
//          the round-robin pointer, forces in_ready low while asserted)
//   bus    stream_mux_rr_if.slave: in_data/in_valid/in_ready, mode, sel,
//          out_data/out_valid/out_ready, out_sel
// ---------------------------------------------------------------------------
module stream_mux_rr #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             reset,
  stream_mux_rr_if.slave   bus
);

  localparam int SEL_W = $clog2(N);

  // Wrapping add on channel indices; correct for non-power-of-2 N because
  // base < N and offset < N, so a single subtract suffices.
  function automatic logic [SEL_W-1:0] rr_index(
    input logic [SEL_W-1:0] base,
    input int               offset
  );
    int sum;
    sum = int'(base) + offset;
    return (sum >= N) ? SEL_W'(sum - N) : SEL_W'(sum);
  endfunction

  // Registered state
  logic [W-1:0]     out_data_r;
  logic             out_valid_r;
  logic [SEL_W-1:0] out_sel_r;
  logic [SEL_W-1:0] ptr_r;

  // Combinational arbitration
  logic             rr_found_s;
  logic [SEL_W-1:0] rr_idx_s;
  logic             fix_found_s;
  logic             grant_found_s;
  logic [SEL_W-1:0] grant_idx_s;
  logic [W-1:0]     grant_data_s;
  logic [SEL_W-1:0] ptr_next_s;
  logic             load_s;
  logic             xfer_s;
  logic [N-1:0]     in_ready_s;

  // Round-robin search: first valid channel at or after ptr, wrapping.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      if (!rr_found_s && bus.in_valid[rr_index(ptr_r, k)]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = rr_index(ptr_r, k);
      end else begin
        // first hit already taken or channel idle: keep scanning
      end
    end
  end

  // Fixed select: an out-of-range sel can never grant.
  always_comb begin
    fix_found_s = 1'b0;
    if (int'(bus.sel) < N) begin
      fix_found_s = bus.in_valid[bus.sel];
    end else begin
      fix_found_s = 1'b0;
    end
  end

  // Mode selects which arbiter result is used this cycle.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    case (bus.mode)
      1'b0: begin
        grant_found_s = rr_found_s;
        grant_idx_s   = rr_idx_s;
      end
      1'b1: begin
        grant_found_s = fix_found_s;
        grant_idx_s   = bus.sel;
      end
      default: begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
      end
    endcase
  end

  // Data path select of the granted channel's word.
  always_comb begin
    grant_data_s = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx_s == SEL_W'(i)) begin
        grant_data_s = bus.in_data[i*W +: W];
      end else begin
        // not the granted channel
      end
    end
  end

  // Slot is loadable when empty or being drained this cycle; a transfer
  // needs a grant and is blocked while reset is held.
  always_comb begin
    load_s = ~out_valid_r | bus.out_ready;
    xfer_s = load_s & grant_found_s & ~reset;
  end

  // One-hot ready to the granted channel only, zero otherwise.
  always_comb begin
    in_ready_s = '0;
    if (xfer_s) begin
      in_ready_s[grant_idx_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  // Pointer advances past the granted channel, wrapping N-1 -> 0.
  always_comb begin
    ptr_next_s = '0;
    if (grant_idx_s == SEL_W'(N - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_idx_s + SEL_W'(1);
    end
  end

  // Output slot register: load on transfer, empty on drain, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_sel_r   <= '0;
    end else if (xfer_s) begin
      out_data_r  <= grant_data_s;
      out_valid_r <= 1'b1;
      out_sel_r   <= grant_idx_s;
    end else if (load_s) begin
      // drained (or already empty) with nothing to refill; data/sel hold
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Round-robin pointer: only round-robin transfers move it, so fixed
  // mode leaves it where round-robin will resume.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (xfer_s && (bus.mode == 1'b0)) begin
      ptr_r <= ptr_next_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sel   = out_sel_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
// ---------------------------------------------------------------------------
// tb_stream_mux_rr
// Directed scenarios plus randomized traffic for stream_mux_rr (N=4, W=8),
// checked against a transaction-level model: a pointer integer, a one-word
// output slot and the arbitration rules evaluated with modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_stream_mux_rr;

  localparam int N = 4;
  localparam int W = 8;

  logic clk;
  logic reset;

  stream_mux_rr_if #(.N(N), .W(W)) bus ();

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  logic [7:0] m_data;
  int         m_sel;

  logic [7:0] chd [N];
  logic [3:0] last_ready;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (bus.mode == 1'b0) begin
      for (int k = 0; k < N; k++) begin
        if (bus.in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
    end
    if (int'(bus.sel) < N && bus.in_valid[bus.sel]) return int'(bus.sel);
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_sel   = 0;
  endtask

  // One cycle: drive after negedge, check ready, advance model on posedge,
  // check the output slot just after the edge.
  task automatic step(input logic [3:0] v, input logic md, input logic [1:0] s, input logic ordy);
    int   g;
    bit   ld;
    logic [3:0] exp_rdy;
    @(negedge clk);
    bus.in_valid  = v;
    bus.mode      = md;
    bus.sel       = s;
    bus.out_ready = ordy;
    for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = chd[i];
    #1;
    g  = model_grant();
    ld = !m_valid || ordy;
    exp_rdy = (ld && g >= 0) ? (4'b0001 << g) : 4'b0000;
    last_ready = bus.in_ready;
    check_val("in_ready", {28'd0, bus.in_ready}, {28'd0, exp_rdy});
    @(posedge clk);
    if (ld && g >= 0) begin
      m_valid = 1'b1;
      m_data  = chd[g];
      m_sel   = g;
      if (md == 1'b0) m_ptr = (g + 1) % N;
    end else if (ld) begin
      m_valid = 1'b0;
    end
    #1;
    check_val("out_valid", {31'd0, bus.out_valid}, {31'd0, m_valid});
    check_val("out_data",  {24'd0, bus.out_data},  {24'd0, m_data});
    check_val("out_sel",   {30'd0, bus.out_sel},   32'(m_sel));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] exp_d;
    reset         = 1'b1;
    bus.in_data   = '0;
    bus.in_valid  = 4'b0000;
    bus.mode      = 1'b0;
    bus.sel       = 2'd0;
    bus.out_ready = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) chd[i] = 8'hA0 + 8'(i);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_val("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_data",  {24'd0, bus.out_data},  32'd0);
    check_val("rst_sel",   {30'd0, bus.out_sel},   32'd0);
    check_val("rst_ready", {28'd0, bus.in_ready},  32'd0);
    reset = 1'b0;

    // Round-robin fairness: A0 A1 A2 A3 A0, no bubbles
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 2'd0, 1'b1);
      exp_d = 8'hA0 + 8'(i % N);
      check_val("rr_data",  {24'd0, bus.out_data}, {24'd0, exp_d});
      check_val("rr_sel",   {30'd0, bus.out_sel},  32'(i % N));
      check_val("rr_valid", {31'd0, bus.out_valid}, 32'd1);
    end

    // Asynchronous reset mid-stream with a word held
    @(negedge clk);
    bus.out_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_val("arst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("arst_data",  {24'd0, bus.out_data},  32'd0);
    check_val("arst_ready", {28'd0, bus.in_ready},  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    check_val("arst_hold", {31'd0, bus.out_valid}, 32'd0);
    reset = 1'b0;
    // Pointer back at 0 after reset
    step(4'b1111, 1'b0, 2'd0, 1'b1);
    check_val("arst_ptr0", {30'd0, bus.out_sel}, 32'd0);

    // Skip and wrap: bring ptr to 3, then only ch1, then only ch3
    step(4'b0100, 1'b0, 2'd0, 1'b1);
    check_val("skip_pre", {30'd0, bus.out_sel}, 32'd2);
    step(4'b0010, 1'b0, 2'd0, 1'b1);
    check_val("skip_ready", {28'd0, last_ready}, 32'h2);
    step(4'b1000, 1'b0, 2'd0, 1'b1);
    check_val("wrap_sel", {30'd0, bus.out_sel}, 32'd3);
    step(4'b1111, 1'b0, 2'd0, 1'b1);
    check_val("wrap_ptr0", {30'd0, bus.out_sel}, 32'd0);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b0, 2'd0, 1'b0);
      check_val("bp_ready", {28'd0, last_ready}, 32'd0);
      check_val("bp_data",  {24'd0, bus.out_data}, 32'hA0);
    end
    step(4'b1111, 1'b0, 2'd0, 1'b1);
    check_val("bp_release_sel",   {30'd0, bus.out_sel},   32'd1);
    check_val("bp_release_valid", {31'd0, bus.out_valid}, 32'd1);

    // Fixed mode sel=2
    for (int i = 0; i < 3; i++) begin
      step(4'b1111, 1'b1, 2'd2, 1'b1);
      check_val("fix_ready", {28'd0, last_ready}, 32'h4);
      check_val("fix_sel",   {30'd0, bus.out_sel}, 32'd2);
    end
    step(4'b1011, 1'b1, 2'd2, 1'b1);
    check_val("fix_none_ready", {28'd0, last_ready},   32'd0);
    check_val("fix_none_valid", {31'd0, bus.out_valid}, 32'd0);
    // Round-robin resumes from ptr=2 (after last rr grant of ch1)
    step(4'b1111, 1'b0, 2'd0, 1'b1);
    check_val("fix_ptr_kept", {30'd0, bus.out_sel}, 32'd2);

    // Idle
    step(4'b0000, 1'b0, 2'd0, 1'b1);
    step(4'b0000, 1'b0, 2'd0, 1'b1);
    check_val("idle_ready", {28'd0, last_ready},   32'd0);
    check_val("idle_valid", {31'd0, bus.out_valid}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) chd[i] = 8'($urandom);
      step(4'($urandom), ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           2'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
